// File: rtl/demod_bit_capture.sv
// Capture engine for the demodulator bit stream: strobe edge detect, optional
// sync-word hunt, LSB-first word packing and a show-ahead FIFO for a reader.
module demod_bit_capture #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SYNC_W    = 32,
    parameter int unsigned CAP_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [SYNC_W-1:0]        sync_word,
    input  logic                     update,
    input  logic                     data_in,
    input  logic                     rd_en,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [1:0]               state,
    output logic [31:0]              bit_count,
    output logic [31:0]              sample_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = $clog2(WORD_W);
    localparam int unsigned WCNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HUNT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_n_c;

    logic                upd_q;
    logic [SYNC_W-2:0]   hist_q;
    logic                bit_ev_c;
    logic                match_c;

    logic                mode_q;
    logic [WORD_W-2:0]   pack_q;
    logic [WORD_W-1:0]   pack_sh_c;
    logic [IDX_W-1:0]    idx_q;
    logic [WCNT_W-1:0]   words_q;
    logic                word_done_c;
    logic                last_word_c;

    logic                arm_ok_c;
    logic                pack_en_c;
    logic                pack_clr_c;
    logic                push_c;

    logic                push_q;
    logic [WORD_W-1:0]   push_word_q;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_n_c;
    logic [LVL_W-1:0]    level_n_c;
    logic                do_pop_c;
    logic                full_c;
    logic                wr_ok_c;
    logic                drop_c;

    // One event per rising strobe; the history window ends with the current bit.
    assign bit_ev_c    = update && !upd_q;
    assign match_c     = ({hist_q, data_in} == sync_word);
    assign pack_sh_c   = {data_in, pack_q};
    assign word_done_c = bit_ev_c && (idx_q == IDX_W'(WORD_W - 1));
    assign last_word_c = (words_q == WCNT_W'(CAP_WORDS - 1));
    assign state       = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n_c;
        end
    end

    always_comb begin
        state_n_c = state_q;
        if (stop) begin
            state_n_c = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (arm) state_n_c = mode ? S_HUNT : S_CAPTURE;
                S_HUNT:    if (bit_ev_c && match_c) state_n_c = S_CAPTURE;
                S_CAPTURE: if (word_done_c && mode_q && last_word_c) state_n_c = S_DONE;
                S_DONE:    state_n_c = S_DONE;
                default:   state_n_c = S_IDLE;
            endcase
        end
    end

    // Datapath controls; stop always wins and throws away the partial word.
    always_comb begin
        arm_ok_c   = 1'b0;
        pack_en_c  = 1'b0;
        pack_clr_c = 1'b0;
        push_c     = 1'b0;
        if (stop) begin
            pack_clr_c = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        arm_ok_c   = 1'b1;
                        pack_clr_c = 1'b1;
                    end
                end
                S_HUNT: begin
                    if (bit_ev_c && match_c) pack_clr_c = 1'b1;
                end
                S_CAPTURE: begin
                    if (bit_ev_c) begin
                        pack_en_c = 1'b1;
                        push_c    = word_done_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q        <= 1'b0;
            hist_q       <= '0;
            bit_count    <= '0;
            sample_count <= '0;
        end else begin
            upd_q        <= update;
            sample_count <= sample_count + 32'd1;
            if (bit_ev_c) begin
                hist_q    <= {hist_q[SYNC_W-3:0], data_in};
                bit_count <= bit_count + 32'd1;
            end
        end
    end

    // Packing: newest bit enters at the MSB so the first bit lands in the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 1'b0;
            pack_q      <= '0;
            idx_q       <= '0;
            words_q     <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q <= push_c;
            if (push_c) push_word_q <= pack_sh_c;
            if (arm_ok_c) mode_q <= mode;
            if (pack_clr_c) begin
                idx_q   <= '0;
                words_q <= '0;
            end else if (pack_en_c) begin
                pack_q <= pack_sh_c[WORD_W-1:1];
                if (push_c) begin
                    idx_q   <= '0;
                    words_q <= words_q + WCNT_W'(1);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push paired with a pop.
    assign do_pop_c   = rd_en && (level != '0);
    assign full_c     = (level == LVL_W'(DEPTH));
    assign wr_ok_c    = push_q && (!full_c || do_pop_c);
    assign drop_c     = push_q && full_c && !do_pop_c;
    assign rd_ptr_n_c = rd_ptr_q + PTR_W'(do_pop_c);
    assign level_n_c  = level + LVL_W'(wr_ok_c) - LVL_W'(do_pop_c);

    always_ff @(posedge clk) begin
        if (wr_ok_c) mem[wr_ptr_q] <= push_word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q <= rd_ptr_n_c;
            level    <= level_n_c;
            rd_valid <= (level_n_c != '0);
            // Bypass the word being written when it becomes the new head.
            if (level_n_c != '0) begin
                rd_data <= (wr_ok_c && (wr_ptr_q == rd_ptr_n_c)) ? push_word_q : mem[rd_ptr_n_c];
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (arm_ok_c) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demod_bit_capture.sv
// Randomised bench for demod_bit_capture: a queue-based behavioural model is
// compared every cycle, plus hand-derived expectations for the directed cases.
module tb_demod_bit_capture;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned SYNC_W    = 32;
    localparam int unsigned CAP_WORDS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic arm = 1'b0;
    logic stop = 1'b0;
    logic update = 1'b0;
    logic data_in = 1'b0;
    logic rd_en = 1'b0;
    logic [SYNC_W-1:0] sync_word = '0;
    logic [WORD_W-1:0] rd_data;
    logic rd_valid;
    logic [$clog2(DEPTH):0] level;
    logic overflow;
    logic [1:0] state;
    logic [31:0] bit_count;
    logic [31:0] sample_count;

    demod_bit_capture #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .SYNC_W(SYNC_W), .CAP_WORDS(CAP_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .arm(arm), .stop(stop),
        .sync_word(sync_word), .update(update), .data_in(data_in), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .overflow(overflow),
        .state(state), .bit_count(bit_count), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: states as integers, FIFO and partial word as queues.
    int          m_state;
    bit          m_mode, m_upd, m_ovf, m_pend;
    bit [31:0]   m_hist, m_bitcnt, m_samp;
    bit          m_bits[$];
    int          m_words;
    bit [7:0]    m_pend_word;
    bit [7:0]    m_q[$];
    bit [7:0]    m_log[$];

    always @(posedge clk or posedge rst) begin : model_b
        bit       ev, pop, old_pend;
        bit [7:0] old_word;
        if (rst) begin
            m_state = 0; m_mode = 0; m_upd = 0; m_ovf = 0; m_pend = 0;
            m_hist = 0; m_bitcnt = 0; m_samp = 0; m_words = 0; m_pend_word = 0;
            m_bits.delete(); m_q.delete(); m_log.delete();
        end else begin
            ev       = update && !m_upd;
            m_upd    = update;
            m_samp   = m_samp + 1;
            old_pend = m_pend;
            old_word = m_pend_word;
            m_pend   = 0;
            pop      = rd_en && (m_q.size() > 0);
            if (stop) begin
                m_state = 0;
                m_bits.delete();
            end else begin
                case (m_state)
                    0: if (arm) begin
                        m_ovf = 0; m_mode = mode; m_state = mode ? 1 : 2;
                        m_bits.delete(); m_words = 0;
                    end
                    1: if (ev && ({m_hist[30:0], data_in} == sync_word)) begin
                        m_state = 2; m_bits.delete(); m_words = 0;
                    end
                    2: if (ev) begin
                        m_bits.push_back(data_in);
                        if (m_bits.size() == int'(WORD_W)) begin
                            for (int i = 0; i < int'(WORD_W); i++) m_pend_word[i] = m_bits[i];
                            m_pend = 1;
                            m_bits.delete();
                            m_words++;
                            if (m_mode && m_words == int'(CAP_WORDS)) m_state = 3;
                        end
                    end
                    default: ;
                endcase
            end
            if (ev) begin
                m_hist   = {m_hist[30:0], data_in};
                m_bitcnt = m_bitcnt + 1;
            end
            if (pop) void'(m_q.pop_front());
            if (old_pend) begin
                if (m_q.size() < int'(DEPTH)) begin
                    m_q.push_back(old_word);
                    m_log.push_back(old_word);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    int          n_chk = 0;
    int          n_err = 0;
    bit          rd_rand = 0;
    bit          samp_chk = 1;
    logic [31:0] samp_off = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("rd_data", 32'(rd_data), 32'(m_q[0]));
        check("level", 32'(level), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("bit_count", bit_count, m_bitcnt);
        if (samp_chk) check("sample_count", sample_count, m_samp + samp_off);
    endtask

    // Advance one cycle, compare at the falling edge, then apply default inputs.
    task automatic step();
        @(negedge clk);
        compare_all();
        arm  = 1'b0;
        stop = 1'b0;
        rd_en = rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic send_bit(input bit b, input int w);
        data_in = b;
        update  = 1'b1;
        step();
        for (int i = 1; i < w; i++) begin
            data_in = 1'($urandom_range(0, 1));
            step();
        end
        update  = 1'b0;
        data_in = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic send_byte(input bit [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], 1);
    endtask

    task automatic do_arm(input bit m);
        mode = m;
        arm  = 1'b1;
        step();
        mode = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1; update = 1'b0; arm = 1'b0; stop = 1'b0; rd_en = 1'b0;
        samp_off = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : stim
        bit [15:0]   pat;
        bit [63:0]   post;
        bit [7:0]    wb;
        bit [7:0]    ow[7];
        bit          found;
        logic [31:0] prev_v;

        // Reset values and counter start
        do_reset();
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_bit_count", bit_count, 32'd0);
        check("samp_after_3", sample_count, 32'd3);

        // Free-run packing
        pat = 16'h0F8D;
        do_arm(1'b0);
        for (int i = 0; i < 16; i++) send_bit(pat[i], 1);
        step();
        check("fr_level", 32'(level), 32'd2);
        check("fr_word0", 32'(rd_data), 32'h8D);
        check("fr_bits", bit_count, 32'd16);
        rd_en = 1'b1;
        step();
        check("fr_word1", 32'(rd_data), 32'h0F);
        rd_en = 1'b1;
        step();
        check("fr_empty", 32'(rd_valid), 32'd0);

        // Sync-triggered capture with random reads
        do_reset();
        sync_word = 32'h8E89BED6;
        rd_rand = 1;
        do_arm(1'b1);
        check("sy_hunt", 32'(state), 32'd1);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 1);
        for (int i = 31; i > 0; i--) send_bit(sync_word[i], 1);
        check("sy_still_hunt", 32'(state), 32'd1);
        send_bit(sync_word[0], 1);
        check("sy_capture", 32'(state), 32'd2);
        post = {$urandom, $urandom};
        for (int i = 0; i < 64; i++) send_bit(post[i], 1);
        check("sy_done", 32'(state), 32'd3);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1);
        repeat (4) step();
        check("sy_nwords", 32'(m_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < m_log.size(); k++)
            check("sy_word", 32'(m_log[k]), 32'(post[8*k +: 8]));
        check("sy_bits", bit_count, 32'd146);
        stop = 1'b1;
        step();
        check("sy_stop_idle", 32'(state), 32'd0);

        // Wide strobe: one event per rising edge
        rd_rand = 0;
        do_reset();
        wb = 8'($urandom);
        do_arm(1'b0);
        for (int i = 0; i < 8; i++) send_bit(wb[i], 5);
        step();
        check("ws_bits", bit_count, 32'd8);
        check("ws_level", 32'(level), 32'd1);
        check("ws_word", 32'(rd_data), 32'(wb));

        // Overflow with DEPTH=4, then push+pop while full
        do_reset();
        for (int k = 0; k < 7; k++) ow[k] = 8'($urandom);
        do_arm(1'b0);
        for (int k = 0; k < 6; k++) send_byte(ow[k]);
        step();
        check("ov_level", 32'(level), 32'd4);
        check("ov_flag", 32'(overflow), 32'd1);
        check("ov_head", 32'(rd_data), 32'(ow[0]));
        for (int i = 0; i < 7; i++) send_bit(ow[6][i], 1);
        data_in = ow[6][7];
        update = 1'b1;
        step();
        update = 1'b0;
        rd_en = 1'b1;
        step();
        check("pp_level", 32'(level), 32'd4);
        check("pp_head", 32'(rd_data), 32'(ow[1]));
        rd_en = 1'b1; step();
        check("ov_w2", 32'(rd_data), 32'(ow[2]));
        rd_en = 1'b1; step();
        check("ov_w3", 32'(rd_data), 32'(ow[3]));
        rd_en = 1'b1; step();
        check("ov_w6", 32'(rd_data), 32'(ow[6]));
        rd_en = 1'b1; step();
        check("ov_drained", 32'(level), 32'd0);

        // Abort mid-word, stop beats arm, re-arm clears overflow
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        stop = 1'b1;
        step();
        check("ab_idle", 32'(state), 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1);
        check("ab_nopush", 32'(level), 32'd0);
        arm = 1'b1;
        stop = 1'b1;
        step();
        check("ab_stop_wins", 32'(state), 32'd0);
        check("ab_ovf_kept", 32'(overflow), 32'd1);
        do_arm(1'b0);
        check("ab_ovf_clr", 32'(overflow), 32'd0);
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        check("rs_pre_level", 32'(level), 32'd1);

        // Asynchronous reset mid-capture
        rst = 1'b1;
        #1;
        check("rs_state", 32'(state), 32'd0);
        check("rs_level", 32'(level), 32'd0);
        check("rs_valid", 32'(rd_valid), 32'd0);
        check("rs_data", 32'(rd_data), 32'd0);
        check("rs_ovf", 32'(overflow), 32'd0);
        check("rs_bits", bit_count, 32'd0);
        check("rs_samp", sample_count, 32'd0);
        do_reset();

        // Pop on empty FIFO
        rd_en = 1'b1;
        step();
        check("ep_level", 32'(level), 32'd0);
        check("ep_valid", 32'(rd_valid), 32'd0);

        // Random traffic against the model
        do_reset();
        sync_word = '0;
        rd_rand = 1;
        for (int i = 0; i < 1500; i++) begin
            arm     = ($urandom_range(0, 19) == 0);
            stop    = ($urandom_range(0, 149) == 0);
            mode    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) update = ~update;
            data_in = ($urandom_range(0, 15) == 0);
            step();
        end
        update = 1'b0;

        // sample_count wrap
        samp_chk = 0;
        force dut.sample_count = 32'hFFFF_FFFE;
        step();
        step();
        release dut.sample_count;
        found = 0;
        prev_v = '0;
        for (int i = 0; i < 6 && !found; i++) begin
            prev_v = sample_count;
            step();
            if (sample_count == 32'd0) found = 1;
        end
        check("samp_wrap_seen", 32'(found), 32'd1);
        check("samp_wrap_prev", prev_v, 32'hFFFF_FFFF);
        samp_off = 32'd0 - m_samp;
        samp_chk = 1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
